led_state_reporter: RTL and testbench

Transmit side of the UART LED application. Whenever the displayed LED pattern or the LED mode switch changes, or the host asks for it, the block snapshots the state. It formats the snapshot as a 4-byte ASCII status frame and serializes it on the UART TX line as 8N1. It sits beside the LED controller, taps its `led` output and `led_switch` input, and drives the board TX pin.

---
 rtl/led_state_reporter_if.sv | 34 +++
 rtl/led_state_reporter.sv | 185 ++++++++++++++++++
 tb/tb_led_state_reporter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_state_reporter_if.sv
// led_state_reporter_if
//   Bundles the LED status taps and the UART TX side of led_state_reporter.
//   Signals:
//     led        [3:0]  current LED pattern (sys_clk domain)
//     led_switch [1:0]  current LED mode select (sys_clk domain)
//     query             single-cycle request for a status frame
//     tx                UART serial output, idles high
//     busy              high while a frame is on the line
//   Modports:
//     master : the LED-controller / host side (drives led, led_switch, query)
//     slave  : the reporter (drives tx, busy)
interface led_state_reporter_if;
  logic [3:0] led;
  logic [1:0] led_switch;
  logic       query;
  logic       tx;
  logic       busy;

  modport master (
    output led,
    output led_switch,
    output query,
    input  tx,
    input  busy
  );

  modport slave (
    input  led,
    input  led_switch,
    input  query,
    output tx,
    output busy
  );
endinterface

// File: rtl/led_state_reporter.sv
// led_state_reporter
//   Watches the LED pattern and mode switch and sends a 4-byte ASCII status
//   frame ("S", '0'+switch, hex digit of led, LF) as 8N1 UART whenever the
//   state differs from the last reported one or the host asks for it.
//   Ports:
//     sys_clk    system clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        led_state_reporter_if.slave (led, led_switch, query in;
//                tx, busy out)
//     state_dbg  current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Request/response semantics: query is a one-cycle pulse with no ready
// handshake; it is never dropped. A query seen while busy is remembered in
// query_pend and any number of such pulses collapse into one frame. A query
// in the same cycle a frame starts is absorbed by that frame. busy rises
// with the start bit and falls at the end of the last stop bit.
module led_state_reporter #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  led_state_reporter_if.slave   bus,
  output logic [1:0]            state_dbg
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD;
  localparam int CNT_W    = $clog2(BAUD_CNT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [3:0]       snap_led_q, snap_led_d;
  logic [1:0]       snap_sw_q, snap_sw_d;
  logic [3:0]       last_led_q, last_led_d;
  logic [1:0]       last_sw_q, last_sw_d;
  logic             query_pend_q, query_pend_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             start_cond;
  logic             bit_end;
  logic [7:0]       cur_byte;

  function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                            input logic [3:0] l,
                                            input logic [1:0] s);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h53;
      2'd1:    b = 8'h30 + {6'd0, s};
      2'd2:    b = (l <= 4'd9) ? (8'h30 + {4'd0, l}) : (8'h37 + {4'd0, l});
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  // Live inputs are compared against the last reported state, so a change
  // made while a frame was on the line still triggers the next frame.
  assign start_cond = (state_q == S_IDLE) &&
                      ((bus.led != last_led_q) ||
                       (bus.led_switch != last_sw_q) ||
                       query_pend_q || bus.query);

  assign bit_end = (baud_q == BAUD_LAST);

  // State register (plus datapath and registered outputs)
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      snap_led_q   <= '0;
      snap_sw_q    <= '0;
      last_led_q   <= '0;
      last_sw_q    <= '0;
      query_pend_q <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      snap_led_q   <= snap_led_d;
      snap_sw_q    <= snap_sw_d;
      last_led_q   <= last_led_d;
      last_sw_q    <= last_sw_d;
      query_pend_q <= query_pend_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    snap_led_d   = snap_led_q;
    snap_sw_d    = snap_sw_q;
    last_led_d   = last_led_q;
    last_sw_d    = last_sw_q;
    query_pend_d = query_pend_q | bus.query;

    case (state_q)
      S_IDLE: begin
        if (start_cond) begin
          state_d      = S_START;
          baud_d       = '0;
          bit_d        = '0;
          byte_d       = '0;
          snap_led_d   = bus.led;
          snap_sw_d    = bus.led_switch;
          last_led_d   = bus.led;
          last_sw_d    = bus.led_switch;
          query_pend_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin // S_STOP
        if (bit_end) begin
          baud_d = '0;
          if (byte_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            // Next byte's start bit follows the stop bit with no gap.
            byte_d  = byte_q + 2'd1;
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Output logic: computed from the next state so tx/busy leave the flops
  // in step with the state they describe.
  always_comb begin
    cur_byte = frame_byte(byte_d, snap_led_q, snap_sw_q);
    tx_d     = 1'b1;
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_led_state_reporter.sv
module tb_led_state_reporter;

  // ---------------- clock / reset ----------------
  logic       sys_clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  led_state_reporter_if bus();

  led_state_reporter #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] b1, input logic [7:0] b2);
    exp_q.push_back(8'h53);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(8'h0A);
  endtask

  // ---------------- UART monitor (samples at bit centres) ----------------
  task automatic mon_wait(input int n, inout bit aborted);
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      if (rst_n !== 1'b1) aborted = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] e;
    bit aborted;
    forever begin
      @(negedge sys_clk);
      if (rst_n === 1'b1 && bus.tx === 1'b0) begin
        aborted = 1'b0;
        rx = '0;
        mon_wait(4, aborted);
        if (!aborted) check("start_bit", 32'(bus.tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          if (!aborted) begin
            mon_wait(10, aborted);
            rx[i] = bus.tx;
          end
        end
        if (!aborted) mon_wait(10, aborted);
        if (!aborted) begin
          check("stop_bit", 32'(bus.tx), 32'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_byte: got %0h expected none at %0t", rx, $time);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", 32'(rx), 32'(e));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge right after busy was seen high; steps one negedge per
  // busy-high clock. Optional query pulses and one led change at given counts.
  task automatic measure_busy(input int q1, input int q2, input int q3,
                              input int chg_at, input logic [3:0] chg_led,
                              output int len);
    len = 0;
    while (bus.busy === 1'b1 && len < 1000) begin
      bus.query = (len == q1 || len == q2 || len == q3);
      if (len == chg_at) bus.led = chg_led;
      len++;
      @(negedge sys_clk);
    end
    bus.query = 1'b0;
  endtask

  // Drive a change (or query pulse) at a negedge and check the start bit
  // appears one clock later.
  task automatic start_frame(input logic [3:0] l, input logic [1:0] s, input bit q);
    @(negedge sys_clk);
    bus.led        = l;
    bus.led_switch = s;
    bus.query      = q;
    @(negedge sys_clk);
    bus.query = 1'b0;
    check("start_latency", {30'd0, bus.tx, bus.busy}, 32'b01);
  endtask

  task automatic check_back_to_back();
    check("gap_idle", {30'd0, bus.tx, bus.busy}, 32'b10);
    @(negedge sys_clk);
    check("back_to_back", {30'd0, bus.tx, bus.busy}, 32'b01);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0] led;
    logic [1:0] sw;
    bit         q;
    logic [7:0] b1;
    logic [7:0] b2;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int len;
    int bad;

    vecs[0] = '{led: 4'hA, sw: 2'd2, q: 1'b0, b1: 8'h32, b2: 8'h41};
    vecs[1] = '{led: 4'hA, sw: 2'd2, q: 1'b1, b1: 8'h32, b2: 8'h41};
    vecs[2] = '{led: 4'h3, sw: 2'd0, q: 1'b0, b1: 8'h30, b2: 8'h33};
    vecs[3] = '{led: 4'h9, sw: 2'd1, q: 1'b0, b1: 8'h31, b2: 8'h39};
    vecs[4] = '{led: 4'hA, sw: 2'd1, q: 1'b0, b1: 8'h31, b2: 8'h41};
    vecs[5] = '{led: 4'hF, sw: 2'd1, q: 1'b0, b1: 8'h31, b2: 8'h46};
    vecs[6] = '{led: 4'h0, sw: 2'd3, q: 1'b0, b1: 8'h33, b2: 8'h30};
    vecs[7] = '{led: 4'h5, sw: 2'd3, q: 1'b0, b1: 8'h33, b2: 8'h35};
    vecs[8] = '{led: 4'h5, sw: 2'd3, q: 1'b1, b1: 8'h33, b2: 8'h35};

    // Reset and idle
    rst_n          = 1'b0;
    bus.led        = 4'h0;
    bus.led_switch = 2'd0;
    bus.query      = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_tx_busy", {30'd0, bus.tx, bus.busy}, 32'b10);
    check("reset_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge sys_clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    check("reset_idle", 32'(bad), 32'd0);

    // Table: change / query frames and hex boundaries
    for (int v = 0; v < 9; v++) begin
      push_frame(vecs[v].b1, vecs[v].b2);
      start_frame(vecs[v].led, vecs[v].sw, vecs[v].q);
      measure_busy(-1, -1, -1, -1, 4'h0, len);
      check("busy_len", 32'(len), 32'd400);
      repeat (20) @(negedge sys_clk);
      check("frame_bytes_left", 32'(exp_q.size()), 32'd0);
      check("idle_after_frame", {30'd0, bus.tx, bus.busy}, 32'b10);
    end

    // Query collapse: three queries during a frame give exactly one more
    push_frame(8'h33, 8'h35);
    push_frame(8'h33, 8'h35);
    start_frame(4'h5, 2'd3, 1'b1);
    measure_busy(50, 100, 200, -1, 4'h0, len);
    check("q_busy_len1", 32'(len), 32'd400);
    check_back_to_back();
    measure_busy(-1, -1, -1, -1, 4'h0, len);
    check("q_busy_len2", 32'(len), 32'd400);
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge sys_clk);
      if (bus.busy !== 1'b0) bad++;
    end
    check("q_no_third_frame", 32'(bad), 32'd0);
    check("q_bytes_left", 32'(exp_q.size()), 32'd0);

    // Mid-frame change: led=3 frame, led=9 at clock 150
    push_frame(8'h33, 8'h33);
    push_frame(8'h33, 8'h39);
    start_frame(4'h3, 2'd3, 1'b0);
    measure_busy(-1, -1, -1, 150, 4'h9, len);
    check("mid_busy_len1", 32'(len), 32'd400);
    check_back_to_back();
    measure_busy(-1, -1, -1, -1, 4'h0, len);
    check("mid_busy_len2", 32'(len), 32'd400);
    repeat (20) @(negedge sys_clk);
    check("mid_bytes_left", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame
    push_frame(8'h32, 8'h36);
    start_frame(4'h6, 2'd2, 1'b0);
    repeat (119) @(negedge sys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_busy", {30'd0, bus.tx, bus.busy}, 32'b10);
    check("rst_mid_state", 32'(state_dbg), 32'd0);
    exp_q.delete();
    push_frame(8'h32, 8'h36);
    repeat (5) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
    check("rst_restart", {30'd0, bus.tx, bus.busy}, 32'b01);
    measure_busy(-1, -1, -1, -1, 4'h0, len);
    check("rst_busy_len", 32'(len), 32'd400);
    repeat (20) @(negedge sys_clk);
    check("rst_bytes_left", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
